sync_updown_ctr5: RTL and testbench

//  5-bit synchronous up/down event counter. Counts rising edges of the count

---
 rtl/sync_updown_ctr5_if.sv | 26 ++
 rtl/sync_updown_ctr5.sv | 43 ++++
 tb/tb_sync_updown_ctr5.sv | 119 +++++++++++
 3 files changed

// File: rtl/sync_updown_ctr5_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_updown_ctr5_if
// Brief    : Strobe/direction inputs and count output of the up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_updown_ctr5_if #(
    parameter int WIDTH = 5
);
    logic             ct;
    logic             cn;
    logic [WIDTH-1:0] op;

    modport master (
        output ct,
        output cn,
        input  op
    );

    modport slave (
        input  ct,
        input  cn,
        output op
    );
endinterface
`default_nettype wire

// File: rtl/sync_updown_ctr5.sv
`default_nettype none
// ============================================================================
// Module   : sync_updown_ctr5
// Brief    : 5-bit synchronous up/down counter of rising edges on cn.
// Revision : 1.0 - initial release
// ============================================================================
module sync_updown_ctr5 #(
    parameter int WIDTH = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sync_updown_ctr5_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_op;
    logic             r_cn_q;
    logic             w_evt;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_nxt;

    assign w_evt = bus.cn & ~r_cn_q;
    assign w_inc = r_op + c_ONE;
    assign w_dec = r_op - c_ONE;
    assign w_nxt = bus.ct ? w_dec : w_inc;

    // cn_q also loads during reset so a strobe already high cannot count on release.
    always_ff @(posedge clk) begin
        r_cn_q <= bus.cn;
        if (rst) begin
            r_op <= c_ZERO;
        end else if (w_evt) begin
            r_op <= w_nxt;
        end
    end

    assign bus.op = r_op;

endmodule
`default_nettype wire

// File: tb/tb_sync_updown_ctr5.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_updown_ctr5
// Brief    : Directed and random stimulus against an arithmetic event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_updown_ctr5;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   m_cnt;
    logic m_prev_cn;

    sync_updown_ctr5_if #(.WIDTH(5)) bus ();

    sync_updown_ctr5 #(.WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [4:0] got, input int exp);
        n_total++;
        if (got !== 5'(exp)) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare op afterwards.
    task automatic step(input logic rst_v, input logic ct_v, input logic cn_v);
        rst    = rst_v;
        bus.ct = ct_v;
        bus.cn = cn_v;
        @(posedge clk);
        if (rst_v)
            m_cnt = 0;
        else if (cn_v && !m_prev_cn)
            m_cnt = (m_cnt + (ct_v ? -1 : 1) + 32) % 32;
        m_prev_cn = cn_v;
        #1;
        check_eq("model", bus.op, m_cnt);
    endtask

    task automatic pulses(input logic ct_v, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, ct_v, 1'b1);
            step(1'b0, ct_v, 1'b0);
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        m_cnt     = 0;
        m_prev_cn = 1'b0;
        rst       = 1'b0;
        bus.ct    = 1'b0;
        bus.cn    = 1'b0;
        @(negedge clk);

        // Reset with strobe high, strobe kept high afterwards
        step(1'b1, 1'b0, 1'b1);
        check_eq("rst_op", bus.op, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check_eq("cn_high_after_rst", bus.op, 0);
        step(1'b0, 1'b0, 1'b0);

        pulses(1'b0, 21);
        check_eq("up21", bus.op, 21);
        pulses(1'b1, 21);
        check_eq("down21", bus.op, 0);

        for (int k = 0; k < 50; k++) begin
            pulses(1'b0, 4);
            pulses(1'b1, 2);
            pulses(1'b0, 8);
            pulses(1'b1, 6);
        end
        check_eq("loop50", bus.op, 8);

        pulses(1'b1, 9);
        check_eq("to31", bus.op, 31);
        pulses(1'b0, 1);
        check_eq("wrap_up", bus.op, 0);
        pulses(1'b1, 1);
        check_eq("wrap_down", bus.op, 31);

        pulses(1'b0, 14);
        check_eq("to13", bus.op, 13);
        step(1'b1, 1'b0, 1'b1);
        check_eq("rst_beats_evt", bus.op, 0);
        step(1'b0, 1'b0, 1'b0);
        pulses(1'b0, 1);
        check_eq("after_rst", bus.op, 1);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("held_once", bus.op, 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("ct_toggle", bus.op, 2);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
